gpio_in_dbnc: RTL
=================

// Module: gpio_in_dbnc
// PURPOSE
//  Input-side front end of the GPIO block: produces the captured pin data and the
//  one-cycle-delayed copy that the GPIO edge-interrupt logic compares.
//  - Synchronises raw pad inputs into mclk.
//  - Optionally debounces each pin with a shared prescaled tick.
//  - Outputs cfg_gpio_data_in (to the cfg read register and the edge detector) and gpio_prev_indata.
// PARAMETERS
//  NPINS      32   number of GPIO pins
//  PRESC_W    16   width of the debounce prescaler
//  DCNT_W     4    width of the per-pin debounce stability counter
// PORTS
//  mclk               in   1        system clock (single clock domain)
//  h_reset_n          in   1        asynchronous active-low reset
//  pad_gpio_in        in   NPINS    raw pad inputs, asynchronous to mclk
//  cfg_gpio_dir_sel   in   NPINS    1 = pin is output; debounce is bypassed for that pin
//  cfg_dbnc_en        in   NPINS    1 = debounce enabled for the pin
//  cfg_dbnc_presc     in   PRESC_W  tick period = cfg_dbnc_presc+1 mclk cycles
//  cfg_dbnc_cnt       in   DCNT_W   stable ticks required to accept a change (0 treated as 1)
//  cfg_gpio_data_in   out  NPINS    filtered pin data
//  gpio_prev_indata   out  NPINS    cfg_gpio_data_in delayed by one mclk
//  dbnc_tick          out  1        prescaler tick, for debug and test
// BEHAVIOUR
//  - Reset: all sync flops, counters, cfg_gpio_data_in, gpio_prev_indata and dbnc_tick = 0.
//  - Sync: 2-flop synchroniser per pin -> sync_in[i]. No other logic between the two flops.
//  - Prescaler: presc_cnt increments every cycle.
//    - When presc_cnt >= cfg_dbnc_presc: dbnc_tick=1 (registered) and presc_cnt wraps to 0.
//    - presc=0 gives a tick every cycle.
//    - Lowering presc below the current count produces a tick on the next cycle, then the new period.
//  - Per pin i, with state dbnc[i] (drives cfg_gpio_data_in[i]) and counter dcnt[i]:
//    - Bypass (cfg_dbnc_en[i]=0 or cfg_gpio_dir_sel[i]=1): dbnc[i] <= sync_in[i] every cycle; dcnt[i] <= 0.
//    - sync_in[i]==dbnc[i]: dcnt[i] <= 0, so a glitch shorter than the threshold is discarded.
//    - sync_in[i]!=dbnc[i] with dbnc_tick=1:
//      - If dcnt[i]+1 >= max(cfg_dbnc_cnt,1): dbnc[i] <= sync_in[i] and dcnt[i] <= 0.
//      - Otherwise dcnt[i] <= dcnt[i]+1.
//    - sync_in[i]!=dbnc[i] with no tick: hold.
//    - dcnt saturates at its maximum value; it never wraps.
//  - gpio_prev_indata <= cfg_gpio_data_in every cycle. Each accepted transition therefore
//    presents exactly one cycle where the two outputs differ, i.e. one edge event downstream.
//  - Latency, pad change to cfg_gpio_data_in:
//    - Bypass: 3 mclk.
//    - Enabled: 2 mclk + time to N ticks, where N = max(cfg_dbnc_cnt,1).
//  - Config changes:
//    - cfg_dbnc_en 1->0 mid-count: counter cleared; pin follows sync_in from the next cycle.
//    - cfg_dbnc_en 0->1: counting starts fresh.
//    - cfg_dbnc_cnt change mid-count: takes effect at the next tick comparison.
//  - Reset release with a pin held high: data goes 0->1 after the normal latency and yields
//    one rising-edge event. Firmware enables edge interrupts only after GPIO initialisation.
//  - Reset asserted mid-operation: all state clears asynchronously; no partial transition survives.
//  - Simultaneous tick and enable de-assert: bypass wins.
// STRUCTURE
//  - Shared pinmux package: GPIO_NPINS=32, GPIO_DBNC_PRESC_W=16, GPIO_DBNC_CNT_W=4.
//  - Top level holds the synchroniser array, the shared prescaler and the prev_indata register.
//  - Sub-module gpio_dbnc_cell: one pin's dbnc/dcnt state, instantiated NPINS times in a generate loop.
// TESTING
//  1 Bypass: en=0, pad[3] 0->1 at cycle 10.
//    -> data_in[3]=1 at cycle 13; prev_indata[3]=1 at cycle 14; no other bit moves.
//  2 Debounce accept: en[5]=1, presc=3, cnt=4, pad[5] held high.
//    -> data_in[5] rises after 2 + 4 ticks (<= 18 cycles); exactly one cycle where prev!=data.
//  3 Glitch reject: same config, pad[5] high for 10 cycles (2 ticks), then low.
//    -> data_in[5] stays 0 and dcnt clears.
//  4 Output pin: dir_sel[7]=1 and en[7]=1, pad[7] toggles every 2 cycles.
//    -> data_in[7] follows with 3-cycle lag and no filtering.
//  5 Mid-count disable: en[2] 1->0 after 2 of 4 ticks, pad high.
//    -> data_in[2]=1 within 1 cycle of sync; counter = 0.
//  6 Async reset mid-count: h_reset_n low for 1 cycle while dcnt[5]=2.
//    -> all outputs 0 immediately; after release, a full 4-tick wait before acceptance.

Source files
------------

// File: rtl/gpio_in_dbnc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_in_dbnc_pkg
// Description : Shared pinmux/GPIO constants and the per-pin debounce mode
//               encoding used by the GPIO input front end.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_in_dbnc_pkg;

    localparam int GPIO_NPINS        = 32;
    localparam int GPIO_DBNC_PRESC_W = 16;
    localparam int GPIO_DBNC_CNT_W   = 4;

    // What a debounce cell does on the coming clock edge.
    typedef enum logic [1:0] {
        DBNC_BYPASS = 2'd0,  // filter off: follow the synchronised input
        DBNC_STABLE = 2'd1,  // input agrees with filtered value: clear counter
        DBNC_WAIT   = 2'd2,  // input differs, no tick: hold
        DBNC_STEP   = 2'd3   // input differs, tick: count or accept
    } dbnc_mode_e;

endpackage : gpio_in_dbnc_pkg
`default_nettype wire

// File: rtl/gpio_dbnc_cell.sv
`default_nettype none
// ============================================================================
// Module      : gpio_dbnc_cell
// Description : One GPIO pin's debounce filter. Holds the filtered value and
//               a saturating stability counter advanced on prescaler ticks.
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_sync_in       - synchronised pad value
//               i_bypass        - 1 = filter off, follow i_sync_in
//               i_tick          - shared prescaler tick
//               i_cnt_cfg       - stable ticks needed (0 behaves as 1)
//               o_dbnc          - filtered pin value
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_dbnc_cell
    import gpio_in_dbnc_pkg::*;
#(
    parameter int DCNT_W = GPIO_DBNC_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_sync_in,
    input  logic              i_bypass,
    input  logic              i_tick,
    input  logic [DCNT_W-1:0] i_cnt_cfg,
    output logic              o_dbnc
);

    logic              r_dbnc;
    logic [DCNT_W-1:0] r_dcnt;

    dbnc_mode_e        w_mode;
    logic [DCNT_W-1:0] w_thr;
    logic [DCNT_W:0]   w_dcnt_inc;
    logic              w_accept;
    logic [DCNT_W-1:0] w_dcnt_sat;

    // A zero threshold would otherwise accept without waiting for a tick.
    assign w_thr      = (i_cnt_cfg == '0) ? DCNT_W'(1) : i_cnt_cfg;
    // One bit wider so the compare is exact even when r_dcnt is all ones.
    assign w_dcnt_inc = {1'b0, r_dcnt} + 1'b1;
    assign w_accept   = (w_dcnt_inc >= {1'b0, w_thr});
    assign w_dcnt_sat = (&r_dcnt) ? r_dcnt : w_dcnt_inc[DCNT_W-1:0];

    // Bypass is decoded first so it wins over a simultaneous tick.
    always_comb begin
        w_mode = DBNC_STABLE;
        if (i_bypass) begin
            w_mode = DBNC_BYPASS;
        end else if (i_sync_in == r_dbnc) begin
            w_mode = DBNC_STABLE;
        end else if (i_tick) begin
            w_mode = DBNC_STEP;
        end else begin
            w_mode = DBNC_WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbnc <= 1'b0;
            r_dcnt <= '0;
        end else begin
            case (w_mode)
                DBNC_BYPASS: begin
                    r_dbnc <= i_sync_in;
                    r_dcnt <= '0;
                end
                DBNC_STABLE: begin
                    r_dcnt <= '0;
                end
                DBNC_STEP: begin
                    if (w_accept) begin
                        r_dbnc <= i_sync_in;
                        r_dcnt <= '0;
                    end else begin
                        r_dcnt <= w_dcnt_sat;
                    end
                end
                default: begin
                    r_dcnt <= r_dcnt;
                end
            endcase
        end
    end

    assign o_dbnc = r_dbnc;

endmodule : gpio_dbnc_cell
`default_nettype wire

// File: rtl/gpio_in_dbnc.sv
`default_nettype none
// ============================================================================
// Module      : gpio_in_dbnc
// Description : GPIO input front end. Synchronises raw pads into mclk,
//               optionally debounces each pin against a shared prescaled
//               tick, and provides the filtered data plus a one-cycle-late
//               copy for the edge-interrupt logic.
// Ports       : mclk, h_reset_n  - clock, async active-low reset
//               pad_gpio_in       - raw asynchronous pad inputs
//               cfg_gpio_dir_sel  - 1 = output pin (filter bypassed)
//               cfg_dbnc_en       - 1 = debounce enabled for the pin
//               cfg_dbnc_presc    - tick period minus one
//               cfg_dbnc_cnt      - stable ticks needed to accept a change
//               cfg_gpio_data_in  - filtered pin data
//               gpio_prev_indata  - cfg_gpio_data_in delayed one cycle
//               dbnc_tick         - prescaler tick
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_in_dbnc
    import gpio_in_dbnc_pkg::*;
#(
    parameter int NPINS   = GPIO_NPINS,
    parameter int PRESC_W = GPIO_DBNC_PRESC_W,
    parameter int DCNT_W  = GPIO_DBNC_CNT_W
) (
    input  logic               mclk,
    input  logic               h_reset_n,
    input  logic [NPINS-1:0]   pad_gpio_in,
    input  logic [NPINS-1:0]   cfg_gpio_dir_sel,
    input  logic [NPINS-1:0]   cfg_dbnc_en,
    input  logic [PRESC_W-1:0] cfg_dbnc_presc,
    input  logic [DCNT_W-1:0]  cfg_dbnc_cnt,
    output logic [NPINS-1:0]   cfg_gpio_data_in,
    output logic [NPINS-1:0]   gpio_prev_indata,
    output logic               dbnc_tick
);

    logic [NPINS-1:0]   r_sync_meta;
    logic [NPINS-1:0]   r_sync_in;
    logic [PRESC_W-1:0] r_presc_cnt;
    logic               r_tick;
    logic [NPINS-1:0]   r_prev_indata;
    logic [NPINS-1:0]   w_bypass;
    logic [NPINS-1:0]   w_data_in;

    // Plain two-flop synchroniser: nothing may sit between the stages.
    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            r_sync_meta <= '0;
            r_sync_in   <= '0;
        end else begin
            r_sync_meta <= pad_gpio_in;
            r_sync_in   <= r_sync_meta;
        end
    end

    // The >= compare (not ==) makes a lowered period take effect on the
    // very next cycle instead of running the counter round its full range.
    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            r_presc_cnt <= '0;
            r_tick      <= 1'b0;
        end else if (r_presc_cnt >= cfg_dbnc_presc) begin
            r_presc_cnt <= '0;
            r_tick      <= 1'b1;
        end else begin
            r_presc_cnt <= r_presc_cnt + 1'b1;
            r_tick      <= 1'b0;
        end
    end

    // Output-direction pins read back what is driven, so never filter them.
    assign w_bypass = ~cfg_dbnc_en | cfg_gpio_dir_sel;

    for (genvar gi = 0; gi < NPINS; gi++) begin : g_pin
        gpio_dbnc_cell #(
            .DCNT_W (DCNT_W)
        ) u_cell (
            .clk       (mclk),
            .rst_n     (h_reset_n),
            .i_sync_in (r_sync_in[gi]),
            .i_bypass  (w_bypass[gi]),
            .i_tick    (r_tick),
            .i_cnt_cfg (cfg_dbnc_cnt),
            .o_dbnc    (w_data_in[gi])
        );
    end

    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            r_prev_indata <= '0;
        end else begin
            r_prev_indata <= w_data_in;
        end
    end

    assign cfg_gpio_data_in = w_data_in;
    assign gpio_prev_indata = r_prev_indata;
    assign dbnc_tick        = r_tick;

endmodule : gpio_in_dbnc
`default_nettype wire
